wr_circ_buf_arb: RTL and testbench

WR_CIRC_BUF_ARB -- requirements
Module: wr_circ_buf_arb

---
 rtl/wr_circ_buf_arb.sv | 145 ++++++++++++++
 tb/tb_wr_circ_buf_arb.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_circ_buf_arb.sv
// Round-robin arbiter that gives one of NUM_SRCS requesters exclusive use of a
// circular-buffer write engine for a whole request / data / completion transaction.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif

module wr_circ_buf_arb #(
    parameter int NUM_SRCS  = 2,
    parameter int BUF_PTR_W = 32,
    parameter int FLOWID_W  = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_SRCS-1:0]                      src_req_val,
    input  logic [NUM_SRCS*FLOWID_W-1:0]             src_req_flowid,
    input  logic [NUM_SRCS*BUF_PTR_W-1:0]            src_req_wr_ptr,
    input  logic [NUM_SRCS*`MSG_DATA_SIZE_WIDTH-1:0] src_req_size,
    output logic [NUM_SRCS-1:0]                      src_req_rdy,
    input  logic [NUM_SRCS-1:0]                      src_req_data_val,
    input  logic [NUM_SRCS*`NOC_DATA_WIDTH-1:0]      src_req_data,
    output logic [NUM_SRCS-1:0]                      src_req_data_rdy,
    output logic [NUM_SRCS-1:0]                      src_req_done,
    input  logic [NUM_SRCS-1:0]                      src_done_rdy,
    output logic                                     arb_wr_buf_req_val,
    output logic [FLOWID_W-1:0]                      arb_wr_buf_req_flowid,
    output logic [BUF_PTR_W-1:0]                     arb_wr_buf_req_wr_ptr,
    output logic [`MSG_DATA_SIZE_WIDTH-1:0]          arb_wr_buf_req_size,
    input  logic                                     wr_buf_arb_req_rdy,
    output logic                                     arb_wr_buf_req_data_val,
    output logic [`NOC_DATA_WIDTH-1:0]               arb_wr_buf_req_data,
    input  logic                                     wr_buf_arb_req_data_rdy,
    input  logic                                     wr_buf_arb_req_done,
    output logic                                     arb_wr_buf_done_rdy
);
    localparam int DATA_W     = `NOC_DATA_WIDTH;
    localparam int SIZE_W     = `MSG_DATA_SIZE_WIDTH;
    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int GNT_W      = $clog2(NUM_SRCS);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t            state_q, state_d;
    logic [GNT_W-1:0]  grant_q, grant_d;
    logic [GNT_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SIZE_W:0]   beats_rem_q, beats_rem_d;
    logic [GNT_W-1:0]  pick;
    logic [SIZE_W:0]   beats_calc;
    logic              req_hs, data_hs, done_hs;

    // Lowest rotational distance from rr_ptr wins, so scan from the far end down.
    always_comb begin
        pick = rr_ptr_q;
        for (int i = NUM_SRCS - 1; i >= 0; i--) begin
            if (src_req_val[(int'(rr_ptr_q) + i) % NUM_SRCS]) begin
                pick = GNT_W'((int'(rr_ptr_q) + i) % NUM_SRCS);
            end
        end
    end

    always_comb begin
        arb_wr_buf_req_flowid = src_req_flowid[int'(grant_q)*FLOWID_W +: FLOWID_W];
        arb_wr_buf_req_wr_ptr = src_req_wr_ptr[int'(grant_q)*BUF_PTR_W +: BUF_PTR_W];
        arb_wr_buf_req_size   = src_req_size[int'(grant_q)*SIZE_W +: SIZE_W];
        arb_wr_buf_req_data   = src_req_data[int'(grant_q)*DATA_W +: DATA_W];
        beats_calc = ({1'b0, arb_wr_buf_req_size} + (SIZE_W+1)'(BEAT_BYTES - 1))
                     / (SIZE_W+1)'(BEAT_BYTES);
        arb_wr_buf_req_val      = 1'b0;
        arb_wr_buf_req_data_val = 1'b0;
        arb_wr_buf_done_rdy     = 1'b0;
        src_req_rdy             = '0;
        src_req_data_rdy        = '0;
        src_req_done            = '0;
        case (state_q)
            REQ: begin
                arb_wr_buf_req_val   = src_req_val[grant_q];
                src_req_rdy[grant_q] = wr_buf_arb_req_rdy;
            end
            DATA: begin
                arb_wr_buf_req_data_val   = src_req_data_val[grant_q];
                src_req_data_rdy[grant_q] = wr_buf_arb_req_data_rdy;
            end
            DONE: begin
                src_req_done[grant_q] = wr_buf_arb_req_done;
                arb_wr_buf_done_rdy   = src_done_rdy[grant_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        req_hs  = (state_q == REQ)  && src_req_val[grant_q] && wr_buf_arb_req_rdy;
        data_hs = (state_q == DATA) && src_req_data_val[grant_q] && wr_buf_arb_req_data_rdy;
        done_hs = (state_q == DONE) && wr_buf_arb_req_done && src_done_rdy[grant_q];
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beats_rem_d = beats_rem_q;
        case (state_q)
            IDLE: begin
                if (|src_req_val) begin
                    grant_d = pick;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (req_hs) begin
                    beats_rem_d = beats_calc;
                    state_d     = (beats_calc == '0) ? DONE : DATA;
                end
            end
            DATA: begin
                if (data_hs) begin
                    beats_rem_d = beats_rem_q - (SIZE_W+1)'(1);
                    if (beats_rem_q == (SIZE_W+1)'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (done_hs) begin
                    rr_ptr_d = GNT_W'((int'(grant_q) + 1) % NUM_SRCS);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beats_rem_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beats_rem_q <= beats_rem_d;
        end
    end
endmodule

// File: tb/tb_wr_circ_buf_arb.sv
// Scoreboard bench for wr_circ_buf_arb: randomized sources and write engine,
// grant order predicted by a rotational model, monitor checks the engine side.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif

module tb_wr_circ_buf_arb;
    localparam int N    = 2;
    localparam int PW   = 32;
    localparam int FW   = 8;
    localparam int DW   = `NOC_DATA_WIDTH;
    localparam int SW   = `MSG_DATA_SIZE_WIDTH;
    localparam int BB   = DW / 8;
    localparam int MAXB = 16;

    typedef struct {
        int          src;
        logic [FW-1:0] flowid;
        logic [PW-1:0] ptr;
        logic [SW-1:0] size;
        int          beats;
    } txn_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    src_req_val, src_req_rdy, src_req_data_val, src_req_data_rdy;
    logic [N-1:0]    src_req_done, src_done_rdy;
    logic [N*FW-1:0] src_req_flowid;
    logic [N*PW-1:0] src_req_wr_ptr;
    logic [N*SW-1:0] src_req_size;
    logic [N*DW-1:0] src_req_data;
    logic            arb_wr_buf_req_val, wr_buf_arb_req_rdy;
    logic [FW-1:0]   arb_wr_buf_req_flowid;
    logic [PW-1:0]   arb_wr_buf_req_wr_ptr;
    logic [SW-1:0]   arb_wr_buf_req_size;
    logic            arb_wr_buf_req_data_val, wr_buf_arb_req_data_rdy;
    logic [DW-1:0]   arb_wr_buf_req_data;
    logic            wr_buf_arb_req_done, arb_wr_buf_done_rdy;
    logic            eng_data_rdy;

    txn_t          exp_q[$];
    logic [DW-1:0] exp_data_q[$];
    txn_t          cur_txn[N];
    logic [DW-1:0] beat_mem[N][MAXB];
    int            tests = 0, fails = 0;
    int            mon_phase = 0, mon_rem = 0, mon_src = 0, txns_done = 0, exp_cnt = 0;
    int            model_rr = 0;
    int            done_hold[N];
    bit            src_busy[N];
    bit            abort = 0, src_random = 0, eng_random = 0, eng_stall = 0;

    wr_circ_buf_arb #(.NUM_SRCS(N), .BUF_PTR_W(PW), .FLOWID_W(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_req_val(src_req_val), .src_req_flowid(src_req_flowid),
        .src_req_wr_ptr(src_req_wr_ptr), .src_req_size(src_req_size),
        .src_req_rdy(src_req_rdy), .src_req_data_val(src_req_data_val),
        .src_req_data(src_req_data), .src_req_data_rdy(src_req_data_rdy),
        .src_req_done(src_req_done), .src_done_rdy(src_done_rdy),
        .arb_wr_buf_req_val(arb_wr_buf_req_val), .arb_wr_buf_req_flowid(arb_wr_buf_req_flowid),
        .arb_wr_buf_req_wr_ptr(arb_wr_buf_req_wr_ptr), .arb_wr_buf_req_size(arb_wr_buf_req_size),
        .wr_buf_arb_req_rdy(wr_buf_arb_req_rdy), .arb_wr_buf_req_data_val(arb_wr_buf_req_data_val),
        .arb_wr_buf_req_data(arb_wr_buf_req_data), .wr_buf_arb_req_data_rdy(wr_buf_arb_req_data_rdy),
        .wr_buf_arb_req_done(wr_buf_arb_req_done), .arb_wr_buf_done_rdy(arb_wr_buf_done_rdy)
    );

    always #5 clk = ~clk;

    assign wr_buf_arb_req_data_rdy = eng_data_rdy & ~eng_stall;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] randBeat();
        logic [DW-1:0] b;
        for (int w = 0; w < DW / 32; w++) b[w*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic prepTxn(input int s, input int size);
        cur_txn[s].src    = s;
        cur_txn[s].flowid = FW'($urandom);
        cur_txn[s].ptr    = $urandom;
        cur_txn[s].size   = (size < 0) ? (($urandom % 4 == 0) ? SW'(0) : SW'($urandom_range(1, MAXB * BB)))
                                       : SW'(size);
        cur_txn[s].beats  = (int'(cur_txn[s].size) + BB - 1) / BB;
        for (int b = 0; b < MAXB; b++) beat_mem[s][b] = randBeat();
    endtask

    task automatic pushTxn(input int s);
        exp_q.push_back(cur_txn[s]);
        for (int b = 0; b < cur_txn[s].beats; b++) exp_data_q.push_back(beat_mem[s][b]);
        exp_cnt++;
    endtask

    // One source's whole transaction: request, data beats, completion.
    task automatic srcRun(input int s);
        txn_t t;
        bit   hs, v;
        int   cyc;
        t = cur_txn[s];
        src_busy[s] = 1'b1;
        src_req_flowid[s*FW +: FW] = t.flowid;
        src_req_wr_ptr[s*PW +: PW] = t.ptr;
        src_req_size[s*SW +: SW]   = t.size;
        src_req_val[s] = 1'b1;
        hs = 0; cyc = 0;
        while (!hs && !abort) begin
            @(negedge clk); hs = src_req_rdy[s];
            @(posedge clk); #1; cyc++;
            if (!hs && cyc > 300) begin
                checkOutput($sformatf("src%0d_req_timeout", s), DW'(hs), DW'(1));
                abort = 1;
            end
        end
        src_req_val[s] = 1'b0;
        for (int b = 0; b < t.beats && !abort; b++) begin
            hs = 0; cyc = 0;
            while (!hs && !abort) begin
                v = src_random ? ($urandom % 4 != 0) : 1'b1;
                src_req_data_val[s] = v;
                src_req_data[s*DW +: DW] = v ? beat_mem[s][b] : randBeat();
                @(negedge clk); hs = v && src_req_data_rdy[s];
                @(posedge clk); #1; cyc++;
                if (!hs && cyc > 300) begin
                    checkOutput($sformatf("src%0d_data_timeout", s), DW'(hs), DW'(1));
                    abort = 1;
                end
            end
        end
        src_req_data_val[s] = 1'b0;
        hs = 0; cyc = 0;
        while (!hs && !abort) begin
            src_done_rdy[s] = (cyc < done_hold[s]) ? 1'b0 : (src_random ? ($urandom % 2 == 0) : 1'b1);
            @(negedge clk);
            checkOutput($sformatf("src%0d_done_rdy_route", s), DW'(arb_wr_buf_done_rdy), DW'(src_done_rdy[s]));
            checkOutput($sformatf("src%0d_done_route", s), DW'(src_req_done[s]), DW'(wr_buf_arb_req_done));
            hs = src_done_rdy[s] && src_req_done[s];
            @(posedge clk); #1; cyc++;
            if (!hs && cyc > 300) begin
                checkOutput($sformatf("src%0d_done_timeout", s), DW'(hs), DW'(1));
                abort = 1;
            end
        end
        src_done_rdy[s] = 1'b0;
        src_busy[s] = 1'b0;
    endtask

    // A round: all masked sources raise requests together; grants follow rotation from rr.
    task automatic applyStimulus(input logic [N-1:0] mask, input int size0, input int size1);
        int last;
        last = model_rr;
        if (mask[0]) prepTxn(0, size0);
        if (mask[1]) prepTxn(1, size1);
        for (int k = 0; k < N; k++) begin
            if (mask[(model_rr + k) % N]) begin
                pushTxn((model_rr + k) % N);
                last = (model_rr + k) % N;
            end
        end
        model_rr = (last + 1) % N;
        fork
            begin if (mask[0]) srcRun(0); end
            begin if (mask[1]) srcRun(1); end
        join
    endtask

    task automatic checkAllQuiet(input string tag);
        checkOutput({tag, "_src_req_rdy"}, DW'(src_req_rdy), '0);
        checkOutput({tag, "_src_data_rdy"}, DW'(src_req_data_rdy), '0);
        checkOutput({tag, "_src_done"}, DW'(src_req_done), '0);
        checkOutput({tag, "_arb_req_val"}, DW'(arb_wr_buf_req_val), '0);
        checkOutput({tag, "_arb_data_val"}, DW'(arb_wr_buf_req_data_val), '0);
        checkOutput({tag, "_arb_done_rdy"}, DW'(arb_wr_buf_done_rdy), '0);
    endtask

    task automatic stallCtl();
        bit            found;
        logic [DW-1:0] held;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk); #2;
            found = (mon_phase == 1 && mon_rem == 7);
        end
        checkOutput("wait_stall_point", DW'(found), DW'(1));
        eng_stall = 1'b1;
        held = (exp_data_q.size() > 0) ? exp_data_q[0] : '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("stall_data_hold", arb_wr_buf_req_data, held);
            checkOutput("stall_data_val", DW'(arb_wr_buf_req_data_val), DW'(1));
            checkOutput("stall_src_data_rdy", DW'(src_req_data_rdy), '0);
            checkOutput("stall_rem", DW'(mon_rem), DW'(7));
        end
        @(posedge clk); #2;
        eng_stall = 1'b0;
    endtask

    // Write engine: randomized or always-ready handshakes.
    initial begin
        wr_buf_arb_req_rdy = 1'b0; eng_data_rdy = 1'b0; wr_buf_arb_req_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            wr_buf_arb_req_rdy  = eng_random ? ($urandom % 4 != 0) : 1'b1;
            eng_data_rdy        = eng_random ? ($urandom % 4 != 0) : 1'b1;
            wr_buf_arb_req_done = eng_random ? ($urandom % 2 == 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every engine-side handshake.
    initial begin
        logic [N-1:0]  oh;
        txn_t          t;
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_phase = 0;
                exp_q.delete();
                exp_data_q.delete();
            end else begin
                oh = '0;
                oh[mon_src] = 1'b1;
                if (mon_phase != 0) begin
                    checkOutput("nongrant_data_rdy", DW'(src_req_data_rdy & ~oh), '0);
                    checkOutput("nongrant_done", DW'(src_req_done & ~oh), '0);
                end
                if (wr_buf_arb_req_done && mon_phase != 2)
                    checkOutput("early_done_rdy", DW'(arb_wr_buf_done_rdy), '0);
                if (arb_wr_buf_req_val && wr_buf_arb_req_rdy) begin
                    checkOutput("req_phase", DW'(mon_phase), '0);
                    checkOutput("req_queue_nonempty", DW'(exp_q.size() > 0), DW'(1));
                    if (exp_q.size() > 0) begin
                        t = exp_q.pop_front();
                        oh = '0;
                        oh[t.src] = 1'b1;
                        checkOutput("req_grant_src", DW'(src_req_rdy), DW'(oh));
                        checkOutput("req_flowid", DW'(arb_wr_buf_req_flowid), DW'(t.flowid));
                        checkOutput("req_wr_ptr", DW'(arb_wr_buf_req_wr_ptr), DW'(t.ptr));
                        checkOutput("req_size", DW'(arb_wr_buf_req_size), DW'(t.size));
                        mon_src = t.src;
                        mon_rem = t.beats;
                        mon_phase = (t.beats > 0) ? 1 : 2;
                    end
                end else if (arb_wr_buf_req_data_val && wr_buf_arb_req_data_rdy) begin
                    checkOutput("data_phase", DW'(mon_phase), DW'(1));
                    checkOutput("data_queue_nonempty", DW'(exp_data_q.size() > 0), DW'(1));
                    if (exp_data_q.size() > 0) begin
                        d = exp_data_q.pop_front();
                        checkOutput("data_beat", arb_wr_buf_req_data, d);
                        checkOutput("data_grant_src", DW'(src_req_data_rdy), DW'(oh));
                    end
                    mon_rem--;
                    if (mon_rem <= 0) mon_phase = 2;
                end else if (wr_buf_arb_req_done && arb_wr_buf_done_rdy) begin
                    checkOutput("done_phase", DW'(mon_phase), DW'(2));
                    checkOutput("done_grant_src", DW'(src_req_done), DW'(oh));
                    mon_phase = 0;
                    txns_done++;
                end
            end
        end
    end

    initial begin
        bit found;
        rst_n = 1'b0;
        src_req_val = '0; src_req_data_val = '0; src_done_rdy = '0;
        src_req_flowid = '0; src_req_wr_ptr = '0; src_req_size = '0; src_req_data = '0;
        done_hold[0] = 0; done_hold[1] = 0;
        src_busy[0] = 0; src_busy[1] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllQuiet("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        applyStimulus(2'b01, 130, 0);
        applyStimulus(2'b11, -1, -1);
        applyStimulus(2'b11, -1, -1);
        done_hold[1] = 3;
        applyStimulus(2'b10, 0, 0);
        done_hold[1] = 0;
        fork
            applyStimulus(2'b01, 640, 0);
            stallCtl();
        join

        eng_random = 1; src_random = 1;
        for (int r = 0; r < 25; r++) applyStimulus(2'($urandom_range(1, 3)), -1, -1);
        eng_random = 0; src_random = 0;

        prepTxn(1, 256);
        pushTxn(1);
        fork
            srcRun(1);
        join_none
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk); #2;
            found = (mon_phase == 1 && mon_rem == 2);
        end
        checkOutput("wait_beats_rem_2", DW'(found), DW'(1));
        rst_n = 1'b0;
        #1;
        checkAllQuiet("midreset");
        abort = 1;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #2;
            found = !src_busy[1];
        end
        checkOutput("src_abort", DW'(found), DW'(1));
        abort = 0;
        exp_cnt--;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_rr = 0;

        applyStimulus(2'b11, -1, -1);
        applyStimulus(2'b11, -1, -1);

        @(negedge clk); @(negedge clk);
        checkOutput("scoreboard_empty", DW'(exp_q.size()), '0);
        checkOutput("txn_count", DW'(txns_done), DW'(exp_cnt));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
